ddr_write_arbiter: RTL and testbench

DDR_WRITE_ARBITER -- requirements
Module: ddr_write_arbiter

---
 rtl/ddr_write_arbiter_pkg.sv | 13 +
 rtl/ddr_write_arbiter_rr_arbiter_2.sv | 27 ++
 rtl/ddr_write_arbiter.sv | 135 +++++++++++++
 tb/tb_ddr_write_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_write_arbiter_pkg.sv
// rtl/ddr_write_arbiter_pkg.sv - shared state encoding and DDR width constants for the write arbiter
package ddr_write_arbiter_pkg;

    localparam int DDR_ADDR_WIDTH  = 32;
    localparam int DDR_DATA_WIDTH  = 64;
    localparam int DDR_BURST_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ddr_write_arbiter_rr_arbiter_2.sv
// rtl/ddr_write_arbiter_rr_arbiter_2.sv - two-way round-robin grant with last-served register
module rr_arbiter_2 (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic owner,
    output logic valid,
    output logic grant
);

    logic last;

    // last resets to 1 so port 0 wins the first tie
    always_ff @(posedge clock) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= owner;
        end
    end

    assign valid = req0 | req1;
    assign grant = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/ddr_write_arbiter.sv
// rtl/ddr_write_arbiter.sv - two-requester DDR write burst arbiter with round-robin tie break
module ddr_write_arbiter
    import ddr_write_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = DDR_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DDR_DATA_WIDTH,
    parameter int BURST_WIDTH = DDR_BURST_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_in0_wr,
    input  logic [ADDR_WIDTH-1:0]   io_in0_addr,
    input  logic [BURST_WIDTH-1:0]  io_in0_burst,
    input  logic [DATA_WIDTH/8-1:0] io_in0_mask,
    input  logic [DATA_WIDTH-1:0]   io_in0_din,
    output logic                    io_in0_wait_n,
    input  logic                    io_in1_wr,
    input  logic [ADDR_WIDTH-1:0]   io_in1_addr,
    input  logic [BURST_WIDTH-1:0]  io_in1_burst,
    input  logic [DATA_WIDTH/8-1:0] io_in1_mask,
    input  logic [DATA_WIDTH-1:0]   io_in1_din,
    output logic                    io_in1_wait_n,
    output logic                    io_ddr_wr,
    output logic [ADDR_WIDTH-1:0]   io_ddr_addr,
    output logic [BURST_WIDTH-1:0]  io_ddr_burst,
    output logic [DATA_WIDTH/8-1:0] io_ddr_mask,
    output logic [DATA_WIDTH-1:0]   io_ddr_din,
    input  logic                    io_ddr_wait_n,
    output logic                    io_busy
);

    localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);

    arb_state_t             state_q, state_d;
    logic                   owner_q, owner_d;
    logic [BURST_WIDTH-1:0] beats_q, beats_d;
    logic [BURST_WIDTH-1:0] len_q, len_d;

    logic                   grant_valid;
    logic                   grant;
    logic                   accept;
    logic                   final_beat;
    logic                   burst_done;
    logic [BURST_WIDTH-1:0] len0;
    logic [BURST_WIDTH-1:0] len1;

    assign len0       = (io_in0_burst == '0) ? ONE : io_in0_burst;
    assign len1       = (io_in1_burst == '0) ? ONE : io_in1_burst;
    assign accept     = io_ddr_wr & io_ddr_wait_n;
    assign final_beat = (beats_q == len_q - ONE);
    assign burst_done = (state_q == ST_BUSY) & accept & final_beat;

    rr_arbiter_2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req0   (io_in0_wr),
        .req1   (io_in1_wr),
        .update (burst_done),
        .owner  (owner_q),
        .valid  (grant_valid),
        .grant  (grant)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            beats_q <= '0;
            len_q   <= ONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beats_d = beats_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_BUSY;
                    owner_d = grant;
                    len_d   = grant ? len1 : len0;
                    beats_d = '0;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    if (final_beat) begin
                        state_d = ST_IDLE;
                        beats_d = '0;
                    end else begin
                        beats_d = beats_q + ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are gated by reset so an abandoned burst never shows another beat
    always_comb begin
        io_busy       = 1'b0;
        io_ddr_wr     = 1'b0;
        io_ddr_addr   = '0;
        io_ddr_burst  = '0;
        io_ddr_mask   = '0;
        io_ddr_din    = '0;
        io_in0_wait_n = 1'b0;
        io_in1_wait_n = 1'b0;
        if (reset && state_q == ST_BUSY) begin
            io_busy      = 1'b1;
            io_ddr_burst = len_q;
            if (owner_q) begin
                io_ddr_wr     = io_in1_wr;
                io_ddr_addr   = io_in1_addr;
                io_ddr_mask   = io_in1_mask;
                io_ddr_din    = io_in1_din;
                io_in1_wait_n = io_ddr_wait_n;
            end else begin
                io_ddr_wr     = io_in0_wr;
                io_ddr_addr   = io_in0_addr;
                io_ddr_mask   = io_in0_mask;
                io_ddr_din    = io_in0_din;
                io_in0_wait_n = io_ddr_wait_n;
            end
        end
    end

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// tb/tb_ddr_write_arbiter.sv - directed scoreboard bench for ddr_write_arbiter
module tb_ddr_write_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int MW = DW / 8;

    typedef struct {
        logic          port;
        logic [AW-1:0] addr;
        logic [BW-1:0] burst;
        logic [MW-1:0] mask;
        logic [DW-1:0] din;
    } beat_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          io_in0_wr, io_in1_wr;
    logic [MW-1:0] io_in0_mask, io_in1_mask;
    logic [DW-1:0] io_in0_din, io_in1_din;
    logic          io_in0_wait_n, io_in1_wait_n;
    logic          io_ddr_wr;
    logic [AW-1:0] io_ddr_addr;
    logic [BW-1:0] io_ddr_burst;
    logic [MW-1:0] io_ddr_mask;
    logic [DW-1:0] io_ddr_din;
    logic          io_ddr_wait_n;
    logic          io_busy;

    int            vectors = 0;
    int            miscompares = 0;
    beat_t         sb[$];
    beat_t         exp_b;

    int            left0 = 0, left1 = 0;
    logic          pause0 = 1'b0, pause1 = 1'b0;
    logic [15:0]   beat0 = '0, beat1 = '0, tag0 = '0, tag1 = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [BW-1:0] burst0 = '0, burst1 = '0;
    logic          hs0 = 1'b0, hs1 = 1'b0;

    function automatic logic [DW-1:0] mk_din(logic p, logic [15:0] tag, logic [15:0] b);
        return {15'h0, p, 16'hD00D, tag, b};
    endfunction

    function automatic logic [MW-1:0] mk_mask(logic p, logic [15:0] tag, logic [15:0] b);
        return tag[7:0] ^ b[7:0] ^ {7'h0, p} ^ 8'h5A;
    endfunction

    task automatic miss(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    assign io_in0_wr   = (left0 != 0) && !pause0;
    assign io_in1_wr   = (left1 != 0) && !pause1;
    assign io_in0_din  = mk_din(1'b0, tag0, beat0);
    assign io_in1_din  = mk_din(1'b1, tag1, beat1);
    assign io_in0_mask = mk_mask(1'b0, tag0, beat0);
    assign io_in1_mask = mk_mask(1'b1, tag1, beat1);

    ddr_write_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .io_in0_wr     (io_in0_wr),
        .io_in0_addr   (addr0),
        .io_in0_burst  (burst0),
        .io_in0_mask   (io_in0_mask),
        .io_in0_din    (io_in0_din),
        .io_in0_wait_n (io_in0_wait_n),
        .io_in1_wr     (io_in1_wr),
        .io_in1_addr   (addr1),
        .io_in1_burst  (burst1),
        .io_in1_mask   (io_in1_mask),
        .io_in1_din    (io_in1_din),
        .io_in1_wait_n (io_in1_wait_n),
        .io_ddr_wr     (io_ddr_wr),
        .io_ddr_addr   (io_ddr_addr),
        .io_ddr_burst  (io_ddr_burst),
        .io_ddr_mask   (io_ddr_mask),
        .io_ddr_din    (io_ddr_din),
        .io_ddr_wait_n (io_ddr_wait_n),
        .io_busy       (io_busy)
    );

    always @(negedge clock) begin
        hs0 = io_in0_wr && io_in0_wait_n;
        hs1 = io_in1_wr && io_in1_wait_n;
        if (io_ddr_wr && io_ddr_wait_n) begin
            vectors++;
            if (sb.size() == 0) miss("sb_nonempty", 0, 1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                vectors++;
                if ((exp_b.port ? io_in1_wait_n : io_in0_wait_n) !== 1'b1)
                    miss("owner_wait_n", exp_b.port ? io_in1_wait_n : io_in0_wait_n, 1);
                vectors++;
                if ((exp_b.port ? io_in0_wait_n : io_in1_wait_n) !== 1'b0)
                    miss("other_wait_n", exp_b.port ? io_in0_wait_n : io_in1_wait_n, 0);
                vectors++;
                if (io_ddr_addr !== exp_b.addr) miss("beat_addr", io_ddr_addr, exp_b.addr);
                vectors++;
                if (io_ddr_burst !== exp_b.burst) miss("beat_burst", io_ddr_burst, exp_b.burst);
                vectors++;
                if (io_ddr_mask !== exp_b.mask) miss("beat_mask", io_ddr_mask, exp_b.mask);
                vectors++;
                if (io_ddr_din !== exp_b.din) miss("beat_din", io_ddr_din, exp_b.din);
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (hs0) begin left0 = left0 - 1; beat0 = beat0 + 16'd1; end
        if (hs1) begin left1 = left1 - 1; beat1 = beat1 + 16'd1; end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic issue(input logic p, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [15:0] tag);
        logic [BW-1:0] eff;
        beat_t e;
        eff = (b == '0) ? BW'(1) : b;
        if (p) begin addr1 = a; burst1 = b; tag1 = tag; beat1 = '0; left1 = int'(eff); end
        else   begin addr0 = a; burst0 = b; tag0 = tag; beat0 = '0; left0 = int'(eff); end
        for (int i = 0; i < int'(eff); i++) begin
            e.port  = p;
            e.addr  = a;
            e.burst = eff;
            e.mask  = mk_mask(p, tag, 16'(i));
            e.din   = mk_din(p, tag, 16'(i));
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (sb.size() == 0 && left0 == 0 && left1 == 0 && !io_busy) begin
                done = 1'b1;
                break;
            end
        end
        vectors++;
        if (done !== 1'b1) miss("drain", done, 1);
    endtask

    task automatic wait_beat0(input logic [15:0] t);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (beat0 == t) begin ok = 1'b1; break; end
            cyc();
        end
        vectors++;
        if (ok !== 1'b1) miss("beat_reach", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp;
        reset = 1'b0;
        io_ddr_wait_n = 1'b1;
        repeat (3) cyc();
        @(negedge clock);
        vectors++; if (io_busy !== 1'b0) miss("rst_busy", io_busy, 0);
        vectors++; if (io_ddr_wr !== 1'b0) miss("rst_ddr_wr", io_ddr_wr, 0);
        vectors++; if (io_ddr_addr !== '0) miss("rst_ddr_addr", io_ddr_addr, 0);
        vectors++; if (io_ddr_burst !== '0) miss("rst_ddr_burst", io_ddr_burst, 0);
        vectors++; if (io_ddr_mask !== '0) miss("rst_ddr_mask", io_ddr_mask, 0);
        vectors++; if (io_ddr_din !== '0) miss("rst_ddr_din", io_ddr_din, 0);
        vectors++; if (io_in0_wait_n !== 1'b0) miss("rst_wait0", io_in0_wait_n, 0);
        vectors++; if (io_in1_wait_n !== 1'b0) miss("rst_wait1", io_in1_wait_n, 0);
        cyc();
        reset = 1'b1;
        cyc();

        issue(1'b0, 32'h1000, 8'd2, 16'd1);
        issue(1'b1, 32'h2000, 8'd2, 16'd2);
        @(negedge clock);
        vectors++; if (io_busy !== 1'b0) miss("tie_c0_busy", io_busy, 0);
        vectors++; if (io_ddr_wr !== 1'b0) miss("tie_c0_wr", io_ddr_wr, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            exp = (c != 3 && c != 6);
            vectors++; if (io_busy !== exp) miss("tie_busy", io_busy, exp);
            vectors++; if (io_ddr_wr !== exp) miss("tie_wr", io_ddr_wr, exp);
        end
        drain();
        issue(1'b0, 32'h1100, 8'd1, 16'd11);
        issue(1'b1, 32'h2100, 8'd1, 16'd12);
        drain();

        cyc();
        issue(1'b0, 32'h3000, 8'd4, 16'd3);
        @(negedge clock);
        vectors++; if (io_busy !== 1'b0) miss("single_c0_busy", io_busy, 0);
        vectors++; if (io_ddr_wr !== 1'b0) miss("single_c0_wr", io_ddr_wr, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            exp = (c <= 4);
            vectors++; if (io_busy !== exp) miss("single_busy", io_busy, exp);
            vectors++; if (io_ddr_wr !== exp) miss("single_wr", io_ddr_wr, exp);
            if (exp) begin
                vectors++; if (io_ddr_addr !== 32'h3000) miss("single_addr", io_ddr_addr, 32'h3000);
            end
        end
        drain();

        cyc();
        issue(1'b0, 32'h4000, 8'd3, 16'd4);
        wait_beat0(16'd1);
        io_ddr_wait_n = 1'b0;
        burst0 = 8'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            vectors++; if (io_in0_wait_n !== 1'b0) miss("stall_wait0", io_in0_wait_n, 0);
            vectors++; if (io_ddr_wr !== 1'b1) miss("stall_wr", io_ddr_wr, 1);
            vectors++;
            if (io_ddr_din !== mk_din(1'b0, 16'd4, 16'd1))
                miss("stall_din", io_ddr_din, mk_din(1'b0, 16'd4, 16'd1));
            vectors++; if (io_ddr_burst !== 8'd3) miss("stall_burst", io_ddr_burst, 3);
            cyc();
        end
        io_ddr_wait_n = 1'b1;
        drain();

        cyc();
        issue(1'b1, 32'h5000, 8'd0, 16'd5);
        @(negedge clock);
        @(negedge clock);
        vectors++; if (io_ddr_wr !== 1'b1) miss("zero_wr", io_ddr_wr, 1);
        vectors++; if (io_ddr_burst !== 8'd1) miss("zero_burst", io_ddr_burst, 1);
        @(negedge clock);
        vectors++; if (io_busy !== 1'b0) miss("zero_done_busy", io_busy, 0);
        drain();

        cyc();
        issue(1'b0, 32'h6000, 8'd4, 16'd6);
        wait_beat0(16'd1);
        pause0 = 1'b1;
        issue(1'b1, 32'h7000, 8'd1, 16'd7);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            vectors++; if (io_busy !== 1'b1) miss("pause_busy", io_busy, 1);
            vectors++; if (io_ddr_wr !== 1'b0) miss("pause_wr", io_ddr_wr, 0);
            vectors++; if (io_in1_wait_n !== 1'b0) miss("pause_wait1", io_in1_wait_n, 0);
            cyc();
        end
        pause0 = 1'b0;
        drain();

        cyc();
        issue(1'b0, 32'h8000, 8'd8, 16'd8);
        wait_beat0(16'd2);
        reset = 1'b0;
        sb.delete();
        issue(1'b0, 32'h8000, 8'd8, 16'd9);
        @(negedge clock);
        vectors++; if (io_ddr_wr !== 1'b0) miss("rstmid_wr", io_ddr_wr, 0);
        vectors++; if (io_busy !== 1'b0) miss("rstmid_busy", io_busy, 0);
        cyc();
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (io_busy !== 1'b0) miss("rstmid_idle_busy", io_busy, 0);
        vectors++; if (io_ddr_wr !== 1'b0) miss("rstmid_idle_wr", io_ddr_wr, 0);
        vectors++; if (io_ddr_addr !== '0) miss("rstmid_idle_addr", io_ddr_addr, 0);
        @(negedge clock);
        vectors++; if (io_busy !== 1'b1) miss("rstmid_regrant", io_busy, 1);
        drain();

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
